// File: rtl/cp0_fwd_tracker_pkg.sv
// Shared defaults and helpers for the CP0 write-tracking / forwarding unit.
// A CP0 address packs the 5-bit register number above the 3-bit select.
package cp0_fwd_tracker_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 8;
    localparam int REG_W  = 5;
    localparam int SEL_W  = 3;

    localparam logic [DEF_AW-1:0] ADDR_ZERO = '0;
    localparam logic [DEF_DW-1:0] DATA_ZERO = '0;

    function automatic logic [DEF_AW-1:0] cp0_addr(input logic [REG_W-1:0] reg_num,
                                                   input logic [SEL_W-1:0] sel);
        return {reg_num, sel};
    endfunction

endpackage

// File: rtl/cp0_fwd_tracker_if.sv
// Bundle of pipeline-side, read-port and commit signals of cp0_fwd_tracker.
// Per-entry and per-port fields are flat vectors, slice k belonging to entry/port k.
interface cp0_fwd_tracker_if
    import cp0_fwd_tracker_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = 3,
    parameter int NRD   = 1
);
    logic                  adv;
    logic                  in_valid;
    logic [AW-1:0]         in_addr;
    logic [DW-1:0]         in_data;
    logic                  in_fin;
    logic [DEPTH-1:0]      upd_en;
    logic [DEPTH*DW-1:0]   upd_data;
    logic [DEPTH-1:0]      flush_mask;
    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rf_data;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_valid;
    logic                  commit_en;
    logic [AW-1:0]         commit_addr;
    logic [DW-1:0]         commit_data;
    logic                  proto_err;
    logic                  hazard_to;

    modport master (
        output adv, in_valid, in_addr, in_data, in_fin,
        output upd_en, upd_data, flush_mask,
        output rd_en, rd_addr, rf_data,
        input  rd_data, rd_valid,
        input  commit_en, commit_addr, commit_data, proto_err, hazard_to
    );

    modport slave (
        input  adv, in_valid, in_addr, in_data, in_fin,
        input  upd_en, upd_data, flush_mask,
        input  rd_en, rd_addr, rf_data,
        output rd_data, rd_valid,
        output commit_en, commit_addr, commit_data, proto_err, hazard_to
    );
endinterface

// File: rtl/cp0_fwd_match.sv
// One read port: youngest-first match over the in-flight entries, falling back
// to the CP0 file. Same-cycle late updates are forwarded and make the data usable.
module cp0_fwd_match
    import cp0_fwd_tracker_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = 3
) (
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0][AW-1:0]  addr,
    input  logic [DEPTH-1:0][DW-1:0]  data,
    input  logic [DEPTH-1:0]          fin,
    input  logic [DEPTH-1:0]          upd_en,
    input  logic [DEPTH-1:0][DW-1:0]  upd_data,
    input  logic [DEPTH-1:0]          flush_mask,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    input  logic [DW-1:0]             rf_data,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_valid
);
    logic [DEPTH-1:0]         hit;
    logic [DEPTH-1:0][DW-1:0] cand_data;
    logic [DEPTH-1:0]         cand_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign hit[gi]        = valid[gi] & ~flush_mask[gi] & (addr[gi] == rd_addr);
        assign cand_data[gi]  = upd_en[gi] ? upd_data[gi] : data[gi];
        assign cand_ready[gi] = fin[gi] | upd_en[gi];
    end

    logic [DW-1:0] sel_data;
    logic          sel_ready;

    // Walk oldest to youngest so the lowest-index hit overrides everything older.
    always_comb begin
        sel_data  = rf_data;
        sel_ready = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel_data  = cand_data[k];
                sel_ready = cand_ready[k];
            end
        end
    end

    assign rd_data  = rd_en ? sel_data : '0;
    assign rd_valid = rd_en ? sel_ready : 1'b1;
endmodule

// File: rtl/cp0_fwd_tracker.sv
// Shadow pipeline of in-flight CP0 writes with late update, flush, in-order
// commit to the CP0 file, per-port forwarding and a stall watchdog.
module cp0_fwd_tracker
    import cp0_fwd_tracker_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int DEPTH   = 3,
    parameter int NRD     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               resetn,
    cp0_fwd_tracker_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [DEPTH-1:0]         valid_reg;
    logic [DEPTH-1:0][AW-1:0] addr_reg;
    logic [DEPTH-1:0][DW-1:0] data_reg;
    logic [DEPTH-1:0]         fin_reg;

    logic [DEPTH-1:0][DW-1:0] upd_data_w;
    logic [DEPTH-1:0]         live;
    logic [DEPTH-1:0][DW-1:0] data_next;
    logic [DEPTH-1:0]         fin_next;

    assign upd_data_w = bus.upd_data;
    assign live       = valid_reg & ~bus.flush_mask;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_post
        assign data_next[gi] = (live[gi] & bus.upd_en[gi]) ? upd_data_w[gi] : data_reg[gi];
        assign fin_next[gi]  = fin_reg[gi] | (live[gi] & bus.upd_en[gi]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            fin_reg   <= '0;
        end else if (bus.adv) begin
            valid_reg[0] <= bus.in_valid;
            addr_reg[0]  <= bus.in_addr;
            data_reg[0]  <= bus.in_data;
            fin_reg[0]   <= bus.in_fin;
            for (int k = 1; k < DEPTH; k++) begin
                valid_reg[k] <= live[k-1];
                addr_reg[k]  <= addr_reg[k-1];
                data_reg[k]  <= data_next[k-1];
                fin_reg[k]   <= fin_next[k-1];
            end
        end else begin
            valid_reg <= live;
            data_reg  <= data_next;
            fin_reg   <= fin_next;
        end
    end

    // Oldest entry leaving the pipeline: commit it if finished, otherwise it is a protocol error.
    logic exit_live;
    logic exit_fin;
    logic commit_en_reg;
    logic [AW-1:0] commit_addr_reg;
    logic [DW-1:0] commit_data_reg;
    logic proto_err_reg;

    assign exit_live = bus.adv & live[DEPTH-1];
    assign exit_fin  = fin_next[DEPTH-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            commit_en_reg   <= 1'b0;
            commit_addr_reg <= '0;
            commit_data_reg <= '0;
            proto_err_reg   <= 1'b0;
        end else begin
            commit_en_reg <= exit_live & exit_fin;
            if (exit_live & exit_fin) begin
                commit_addr_reg <= addr_reg[DEPTH-1];
                commit_data_reg <= data_next[DEPTH-1];
            end
            if (exit_live & ~exit_fin) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    logic [NRD-1:0][DW-1:0] rd_data_w;
    logic [NRD-1:0][AW-1:0] rd_addr_w;
    logic [NRD-1:0][DW-1:0] rf_data_w;
    logic [NRD-1:0]         rd_valid_w;

    assign rd_addr_w = bus.rd_addr;
    assign rf_data_w = bus.rf_data;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        cp0_fwd_match #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_match (
            .valid      (valid_reg),
            .addr       (addr_reg),
            .data       (data_reg),
            .fin        (fin_reg),
            .upd_en     (bus.upd_en),
            .upd_data   (upd_data_w),
            .flush_mask (bus.flush_mask),
            .rd_en      (bus.rd_en[gi]),
            .rd_addr    (rd_addr_w[gi]),
            .rf_data    (rf_data_w[gi]),
            .rd_data    (rd_data_w[gi]),
            .rd_valid   (rd_valid_w[gi])
        );
    end

    logic stall;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic hazard_to_reg;

    assign stall = |(bus.rd_en & ~rd_valid_w);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
            hazard_to_reg <= 1'b0;
        end else if (stall) begin
            if (stall_cnt_reg != CNT_W'(TIMEOUT)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (stall_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                hazard_to_reg <= 1'b1;
            end
        end else begin
            stall_cnt_reg <= '0;
        end
    end

    assign bus.rd_data     = rd_data_w;
    assign bus.rd_valid    = rd_valid_w;
    assign bus.commit_en   = commit_en_reg;
    assign bus.commit_addr = commit_addr_reg;
    assign bus.commit_data = commit_data_reg;
    assign bus.proto_err   = proto_err_reg;
    assign bus.hazard_to   = hazard_to_reg;
endmodule

// File: tb/tb_cp0_fwd_tracker.sv
// Bench for cp0_fwd_tracker: an age-ordered model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_cp0_fwd_tracker;
    import cp0_fwd_tracker_pkg::*;

    localparam int DW = 32, AW = 8, DEPTH = 3, NRD = 2, TIMEOUT = 8;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    cp0_fwd_tracker_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NRD(NRD)) bus ();

    cp0_fwd_tracker #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: entries listed youngest first ----------------
    typedef struct {
        bit            v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            f;
    } ent_t;

    ent_t          pipe [DEPTH];
    bit            m_cen;
    logic [AW-1:0] m_caddr;
    logic [DW-1:0] m_cdata;
    bit            m_perr;
    bit            m_haz;
    int            m_run;

    function automatic void model_read(input int p, output logic [DW-1:0] d, output bit ok);
        d  = bus.rf_data[p*DW +: DW];
        ok = 1'b1;
        if (!bus.rd_en[p]) begin
            d = '0;
            return;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (pipe[k].v && !bus.flush_mask[k] && pipe[k].a == bus.rd_addr[p*AW +: AW]) begin
                if (bus.upd_en[k]) begin
                    d  = bus.upd_data[k*DW +: DW];
                    ok = 1'b1;
                end else begin
                    d  = pipe[k].d;
                    ok = pipe[k].f;
                end
                return;
            end
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) pipe[k] = '{1'b0, '0, '0, 1'b0};
            m_cen = 0; m_caddr = '0; m_cdata = '0; m_perr = 0; m_haz = 0; m_run = 0;
        end else begin
            bit            any_stall;
            logic [DW-1:0] dd;
            bit            ok;
            ent_t          post [DEPTH];
            any_stall = 1'b0;
            for (int p = 0; p < NRD; p++) begin
                model_read(p, dd, ok);
                if (!ok) any_stall = 1'b1;
            end
            for (int k = 0; k < DEPTH; k++) begin
                post[k] = pipe[k];
                if (bus.flush_mask[k]) post[k].v = 1'b0;
                if (post[k].v && bus.upd_en[k]) begin
                    post[k].d = bus.upd_data[k*DW +: DW];
                    post[k].f = 1'b1;
                end
            end
            m_cen = 1'b0;
            if (bus.adv) begin
                if (post[DEPTH-1].v) begin
                    if (post[DEPTH-1].f) begin
                        m_cen   = 1'b1;
                        m_caddr = post[DEPTH-1].a;
                        m_cdata = post[DEPTH-1].d;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                for (int k = DEPTH - 1; k >= 1; k--) pipe[k] = post[k-1];
                pipe[0] = '{bus.in_valid, bus.in_addr, bus.in_data, bus.in_fin};
            end else begin
                for (int k = 0; k < DEPTH; k++) pipe[k] = post[k];
            end
            m_run = any_stall ? ((m_run < TIMEOUT) ? m_run + 1 : TIMEOUT) : 0;
            if (m_run == TIMEOUT) m_haz = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [DW-1:0] dd;
            bit            ok;
            for (int p = 0; p < NRD; p++) begin
                model_read(p, dd, ok);
                chk($sformatf("model rd_data[%0d]", p), 64'(bus.rd_data[p*DW +: DW]), 64'(dd));
                chk($sformatf("model rd_valid[%0d]", p), 64'(bus.rd_valid[p]), 64'(ok));
            end
            chk("model commit_en", 64'(bus.commit_en), 64'(m_cen));
            chk("model commit_addr", 64'(bus.commit_addr), 64'(m_caddr));
            chk("model commit_data", 64'(bus.commit_data), 64'(m_cdata));
            chk("model proto_err", 64'(bus.proto_err), 64'(m_perr));
            chk("model hazard_to", 64'(bus.hazard_to), 64'(m_haz));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        bus.adv = 1'b0; bus.in_valid = 1'b0; bus.in_addr = ADDR_ZERO; bus.in_data = DATA_ZERO;
        bus.in_fin = 1'b0; bus.upd_en = '0; bus.upd_data = '0; bus.flush_mask = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
        bus.adv = 1'b1; bus.in_valid = 1'b1; bus.in_addr = a; bus.in_data = d; bus.in_fin = f;
        tick();
        clr();
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        bus.rd_addr[AW-1:0] = a;
        bus.rf_data[DW-1:0] = rf;
    endtask

    initial begin
        clr();
        bus.rd_en = '0; bus.rd_addr = '0; bus.rf_data = '0;
        #2 resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        chk_on = 1'b1;

        // Idle after reset: read falls through to the CP0 file
        bus.rd_en = 2'b01;
        rd0(cp0_addr(5'd12, 3'd0), 32'h1234);
        @(negedge clk);
        chk("reset rd_data", 64'(bus.rd_data[DW-1:0]), 64'h1234);
        chk("reset rd_valid", 64'(bus.rd_valid[0]), 64'h1);
        chk("reset commit_en", 64'(bus.commit_en), 64'h0);
        chk("reset commit_data", 64'(bus.commit_data), 64'h0);
        chk("reset proto_err", 64'(bus.proto_err), 64'h0);
        chk("reset hazard_to", 64'(bus.hazard_to), 64'h0);
        $display("txn reset/idle read 0x60");

        // Youngest wins, then in-order commit
        push(8'h60, 32'hAAAA, 1'b1);
        push(8'h60, 32'hBBBB, 1'b1);
        bus.rd_en = 2'b11;
        bus.rd_addr[2*AW-1:AW] = 8'h60;
        bus.rf_data[2*DW-1:DW] = 32'h77;
        @(negedge clk);
        chk("youngest rd_data0", 64'(bus.rd_data[DW-1:0]), 64'hBBBB);
        chk("youngest rd_data1", 64'(bus.rd_data[2*DW-1:DW]), 64'hBBBB);
        bus.adv = 1'b1;
        tick();
        @(negedge clk);
        chk("commit none yet", 64'(bus.commit_en), 64'h0);
        tick();
        @(negedge clk);
        chk("commit1 en", 64'(bus.commit_en), 64'h1);
        chk("commit1 addr", 64'(bus.commit_addr), 64'h60);
        chk("commit1 data", 64'(bus.commit_data), 64'hAAAA);
        tick();
        @(negedge clk);
        chk("commit2 en", 64'(bus.commit_en), 64'h1);
        chk("commit2 data", 64'(bus.commit_data), 64'hBBBB);
        bus.adv = 1'b0;
        bus.rd_en = 2'b01;
        tick();
        @(negedge clk);
        chk("commit pulse ends", 64'(bus.commit_en), 64'h0);
        chk("commit data held", 64'(bus.commit_data), 64'hBBBB);
        $display("txn forward youngest + commit AAAA,BBBB");

        // Unfinished hit stalls, late update releases it in the same cycle
        push(8'h68, 32'h1111, 1'b0);
        rd0(8'h68, 32'h3333);
        @(negedge clk);
        chk("unfinished rd_valid", 64'(bus.rd_valid[0]), 64'h0);
        bus.adv = 1'b1;
        tick();
        bus.adv = 1'b0;
        bus.upd_en = 3'b010;
        bus.upd_data = {32'h0, 32'hC0DE, 32'h0};
        @(negedge clk);
        chk("upd same-cycle valid", 64'(bus.rd_valid[0]), 64'h1);
        chk("upd same-cycle data", 64'(bus.rd_data[DW-1:0]), 64'hC0DE);
        tick();
        clr();
        @(negedge clk);
        chk("upd fin held valid", 64'(bus.rd_valid[0]), 64'h1);
        chk("upd fin held data", 64'(bus.rd_data[DW-1:0]), 64'hC0DE);
        bus.adv = 1'b1;
        tick(); tick();
        bus.adv = 1'b0;
        @(negedge clk);
        chk("upd commit en", 64'(bus.commit_en), 64'h1);
        chk("upd commit addr", 64'(bus.commit_addr), 64'h68);
        chk("upd commit data", 64'(bus.commit_data), 64'hC0DE);
        $display("txn late update 0x68 -> C0DE committed");

        // Unfinished entry exits: protocol error, no commit
        rd0(8'h10, 32'h2222);
        push(8'h70, 32'h5555, 1'b0);
        bus.adv = 1'b1;
        tick(); tick(); tick();
        bus.adv = 1'b0;
        @(negedge clk);
        chk("proto no commit", 64'(bus.commit_en), 64'h0);
        chk("proto_err set", 64'(bus.proto_err), 64'h1);
        tick(); tick();
        @(negedge clk);
        chk("proto_err sticky", 64'(bus.proto_err), 64'h1);
        $display("txn unfinished exit -> proto_err");

        // Flush all with a finished oldest entry
        push(8'h74, 32'hDDDD, 1'b1);
        push(8'h78, 32'hEEEE, 1'b1);
        bus.adv = 1'b1;
        tick();
        bus.flush_mask = 3'b111;
        rd0(8'h74, 32'h9999);
        @(negedge clk);
        chk("flush read rf", 64'(bus.rd_data[DW-1:0]), 64'h9999);
        tick();
        clr();
        @(negedge clk);
        chk("flush no commit", 64'(bus.commit_en), 64'h0);
        chk("flush data held", 64'(bus.commit_data), 64'hC0DE);
        rd0(8'h78, 32'hAB);
        @(negedge clk);
        chk("flushed 0x78 gone", 64'(bus.rd_data[DW-1:0]), 64'hAB);
        $display("txn flush all -> no commit");

        // Watchdog: break at TIMEOUT-1 prevents it, full run trips it
        push(8'h7C, 32'h1, 1'b0);
        rd0(8'h7C, 32'h0);
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        chk("wd before break", 64'(bus.hazard_to), 64'h0);
        bus.rd_en = 2'b00;
        tick();
        bus.rd_en = 2'b01;
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        chk("wd after break", 64'(bus.hazard_to), 64'h0);
        tick();
        @(negedge clk);
        chk("wd trips", 64'(bus.hazard_to), 64'h1);
        bus.rd_en = 2'b00;
        tick(); tick();
        @(negedge clk);
        chk("wd sticky", 64'(bus.hazard_to), 64'h1);
        $display("txn watchdog TIMEOUT=%0d", TIMEOUT);

        // Reset mid-operation discards in-flight entries
        bus.rd_en = 2'b01;
        rd0(8'h60, 32'h5A5A);
        push(8'h60, 32'h4242, 1'b1);
        bus.adv = 1'b1;
        tick();
        bus.adv = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst hazard_to", 64'(bus.hazard_to), 64'h0);
        chk("rst proto_err", 64'(bus.proto_err), 64'h0);
        chk("rst commit_data", 64'(bus.commit_data), 64'h0);
        chk("rst entry gone", 64'(bus.rd_data[DW-1:0]), 64'h5A5A);
        bus.adv = 1'b1;
        repeat (DEPTH) tick();
        bus.adv = 1'b0;
        @(negedge clk);
        chk("rst no commit", 64'(bus.commit_en), 64'h0);
        $display("txn reset mid-operation");

        tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
